// File: rtl/gray_code_generator.sv
// Up/down 4-bit counter stepped by debounced buttons, emitting bin and Gray code, plus a
// two-digit (units/tens) time-multiplexed 7-segment driver.
module gray_code_generator #(
   parameter int unsigned DEBOUNCE_CYCLES = 10,
   parameter int unsigned REFRESH_CYCLES  = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_up,
   input  logic       btn_down,
   output logic [3:0] GrayCode,
   output logic [3:0] bin,
   output logic       changed,
   output logic [6:0] seg,
   output logic       transistor_unidades,
   output logic       transistor_decenas
);

   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned RfW = $clog2(REFRESH_CYCLES);
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RfW-1:0] RfLast = RfW'(REFRESH_CYCLES - 1);

   typedef enum logic {SelUnits, SelTens} sel_e;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      case (d)
         4'd0:    seg_of = 7'b1111110;
         4'd1:    seg_of = 7'b0110000;
         4'd2:    seg_of = 7'b1101101;
         4'd3:    seg_of = 7'b1111001;
         4'd4:    seg_of = 7'b0110011;
         4'd5:    seg_of = 7'b1011011;
         4'd6:    seg_of = 7'b1011111;
         4'd7:    seg_of = 7'b1110000;
         4'd8:    seg_of = 7'b1111111;
         4'd9:    seg_of = 7'b1111011;
         default: seg_of = 7'b0000000;
      endcase
   endfunction

   // Bit 0 carries the up button, bit 1 the down button.
   logic [1:0]     sync1_q, sync2_q;
   logic [1:0]     deb_q, deb_d, deb_prev_q;
   logic [1:0]     step_q, step_d;
   logic [DbW-1:0] db_cnt_q [2];
   logic [DbW-1:0] db_cnt_d [2];

   logic [3:0]     bin_q, bin_d, gray_q, gray_d, units;
   logic           changed_q, changed_d;
   logic           up, dn;

   logic [RfW-1:0] rf_cnt_q, rf_cnt_d;
   sel_e           sel_q, sel_d;
   logic [6:0]     seg_q, seg_d;
   logic           tu_q, tu_d, td_q, td_d;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         deb_d[i]    = deb_q[i];
         db_cnt_d[i] = '0;
         if (sync2_q[i] != deb_q[i]) begin
            if (db_cnt_q[i] == DbLast) begin
               deb_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
         end
      end
      // Registered rising-edge detect: releases never step.
      step_d = deb_q & ~deb_prev_q;
   end

   assign up = step_q[0];
   assign dn = step_q[1];

   always_comb begin
      bin_d = bin_q;
      if (up && !dn) begin
         bin_d = bin_q + 4'd1;
      end else if (dn && !up) begin
         bin_d = bin_q - 4'd1;
      end
      gray_d    = bin_d ^ (bin_d >> 1);
      changed_d = up ^ dn;
   end

   assign units = (bin_q >= 4'd10) ? (bin_q - 4'd10) : bin_q;

   always_comb begin
      rf_cnt_d = rf_cnt_q + 1'b1;
      sel_d    = sel_q;
      seg_d    = seg_q;
      tu_d     = tu_q;
      td_d     = td_q;
      // Segments and enables swap together so the bus always matches the lit digit.
      if (rf_cnt_q == RfLast) begin
         rf_cnt_d = '0;
         sel_d    = (sel_q == SelUnits) ? SelTens : SelUnits;
         if (sel_d == SelUnits) begin
            seg_d = seg_of(units);
            tu_d  = 1'b1;
            td_d  = 1'b0;
         end else begin
            seg_d = (bin_q >= 4'd10) ? seg_of(4'd1) : 7'b0000000;
            tu_d  = 1'b0;
            td_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         deb_q      <= '0;
         deb_prev_q <= '0;
         step_q     <= '0;
         for (int i = 0; i < 2; i++) begin
            db_cnt_q[i] <= '0;
         end
         bin_q      <= '0;
         gray_q     <= '0;
         changed_q  <= 1'b0;
         rf_cnt_q   <= '0;
         sel_q      <= SelUnits;
         seg_q      <= 7'b1111110;
         tu_q       <= 1'b1;
         td_q       <= 1'b0;
      end else begin
         sync1_q    <= {btn_down, btn_up};
         sync2_q    <= sync1_q;
         deb_q      <= deb_d;
         deb_prev_q <= deb_q;
         step_q     <= step_d;
         for (int i = 0; i < 2; i++) begin
            db_cnt_q[i] <= db_cnt_d[i];
         end
         bin_q      <= bin_d;
         gray_q     <= gray_d;
         changed_q  <= changed_d;
         rf_cnt_q   <= rf_cnt_d;
         sel_q      <= sel_d;
         seg_q      <= seg_d;
         tu_q       <= tu_d;
         td_q       <= td_d;
      end
   end

   assign GrayCode            = gray_q;
   assign bin                 = bin_q;
   assign changed             = changed_q;
   assign seg                 = seg_q;
   assign transistor_unidades = tu_q;
   assign transistor_decenas  = td_q;

endmodule

// File: tb/tb_gray_code_generator.sv
// Self-checking bench: directed and random button stimulus against an edge-history model.
module tb_gray_code_generator;

   localparam int unsigned D = 10;
   localparam int unsigned R = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_up = 1'b0;
   logic       btn_down = 1'b0;
   logic [3:0] GrayCode, bin;
   logic       changed;
   logic [6:0] seg;
   logic       tu, td;

   int n_checks = 0;
   int n_fail   = 0;

   gray_code_generator #(
      .DEBOUNCE_CYCLES(D),
      .REFRESH_CYCLES (R)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .btn_up              (btn_up),
      .btn_down            (btn_down),
      .GrayCode            (GrayCode),
      .bin                 (bin),
      .changed             (changed),
      .seg                 (seg),
      .transistor_unidades (tu),
      .transistor_decenas  (td)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'b1111110;
         1: return 7'b0110000;
         2: return 7'b1101101;
         3: return 7'b1111001;
         4: return 7'b0110011;
         5: return 7'b1011011;
         6: return 7'b1011111;
         7: return 7'b1110000;
         8: return 7'b1111111;
         9: return 7'b1111011;
         default: return 7'b0000000;
      endcase
   endfunction

   // Model: per-edge history of button samples (cleared by reset). A level flips once the
   // last D synchronized samples all disagree with it; bin moves two edges after the flip.
   bit         hu[$];
   bit         hd[$];
   bit  [1:0]  m_deb, r1, r2;
   logic [3:0] m_bin, m_gray;
   logic       m_chg, m_tu, m_td;
   logic [6:0] m_seg;
   int         n_rel;

   function automatic bit flips(input bit q[$], input bit lvl);
      if (q.size() < int'(D) + 1) return 1'b0;
      for (int k = 0; k < int'(D); k++) begin
         if (q[q.size() - 2 - k] == lvl) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_step();
      bit up, dn, nu, nd;
      if (rst) begin
         hu.delete();
         hd.delete();
         m_deb  = '0;
         r1     = '0;
         r2     = '0;
         m_bin  = 4'd0;
         m_gray = 4'd0;
         m_chg  = 1'b0;
         m_seg  = 7'b1111110;
         m_tu   = 1'b1;
         m_td   = 1'b0;
         n_rel  = 0;
      end else begin
         n_rel++;
         if (n_rel % int'(R) == 0) begin
            if (((n_rel / int'(R)) % 2) == 1) begin
               m_tu  = 1'b0;
               m_td  = 1'b1;
               m_seg = (m_bin >= 4'd10) ? seg_of(1) : 7'b0000000;
            end else begin
               m_tu  = 1'b1;
               m_td  = 1'b0;
               m_seg = seg_of(int'(m_bin) % 10);
            end
         end
         up    = r2[0];
         dn    = r2[1];
         m_chg = up ^ dn;
         if (up && !dn) m_bin = m_bin + 4'd1;
         else if (dn && !up) m_bin = m_bin - 4'd1;
         m_gray = m_bin ^ (m_bin >> 1);
         r2 = r1;
         nu = flips(hu, m_deb[0]);
         nd = flips(hd, m_deb[1]);
         r1[0] = nu && !m_deb[0];
         r1[1] = nd && !m_deb[1];
         if (nu) m_deb[0] = !m_deb[0];
         if (nd) m_deb[1] = !m_deb[1];
         hu.push_back(btn_up);
         hd.push_back(btn_down);
         if (hu.size() > int'(D) + 2) void'(hu.pop_front());
         if (hd.size() > int'(D) + 2) void'(hd.pop_front());
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         chk("bin", bin, m_bin);
         chk("gray", GrayCode, m_gray);
         chk("changed", changed, m_chg);
         chk("seg", seg, m_seg);
         chk("en_units", tu, m_tu);
         chk("en_tens", td, m_td);
         chk("en_onehot", tu ^ td, 1);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit up, input bit dn, input int hold);
      @(negedge clk);
      btn_up   = up;
      btn_down = dn;
      cyc(hold);
      btn_up   = 1'b0;
      btn_down = 1'b0;
      cyc(int'(D) + 8);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_bin"}, bin, 0);
      chk({tag, "_gray"}, GrayCode, 0);
      chk({tag, "_changed"}, changed, 0);
      chk({tag, "_seg"}, seg, 7'b1111110);
      chk({tag, "_tu"}, tu, 1);
      chk({tag, "_td"}, td, 0);
   endtask

   initial begin
      cyc(3);
      chk_reset_vals("reset");
      rst = 1'b0;
      cyc(40);
      chk("idle_bin", bin, 0);

      // Step latency: E0 is the first edge that samples btn_up high.
      @(negedge clk);
      btn_up = 1'b1;
      @(posedge clk);
      repeat (int'(D) + 2) @(posedge clk);
      #1 chk("lat_before", bin, 0);
      @(posedge clk);
      #1;
      chk("lat_bin", bin, 1);
      chk("lat_gray", GrayCode, 4'b0001);
      chk("lat_changed", changed, 1);
      @(posedge clk);
      #1 chk("lat_changed_drop", changed, 0);
      cyc(20);
      btn_up = 1'b0;
      cyc(int'(D) + 8);
      chk("no_repeat", bin, 1);

      repeat (14) press(1'b1, 1'b0, 15);
      chk("up15_bin", bin, 15);
      chk("up15_gray", GrayCode, 4'b1000);
      press(1'b1, 1'b0, 15);
      chk("wrap_up_bin", bin, 0);
      chk("wrap_up_gray", GrayCode, 4'b0000);
      press(1'b0, 1'b1, 15);
      chk("wrap_dn_bin", bin, 15);
      chk("wrap_dn_gray", GrayCode, 4'b1000);

      repeat (10) begin
         btn_up = 1'b1;
         cyc(5);
         btn_up = 1'b0;
         cyc(5);
      end
      cyc(int'(D) + 8);
      chk("glitch", bin, 15);

      press(1'b1, 1'b1, 20);
      chk("both", bin, 15);

      repeat (3) press(1'b0, 1'b1, 15);
      chk("b12_bin", bin, 12);
      chk("b12_gray", GrayCode, 4'b1010);
      repeat (4 * R) begin
         @(negedge clk);
         if (tu) chk("seg_units12", seg, 7'b1101101);
         if (td) chk("seg_tens12", seg, 7'b0110000);
      end

      repeat (5) press(1'b0, 1'b1, 15);
      chk("b7_bin", bin, 7);
      @(negedge clk);
      btn_up = 1'b1;
      cyc(6);
      rst = 1'b1;
      @(posedge clk);
      #1 chk_reset_vals("midrst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      repeat (int'(D) + 2) @(posedge clk);
      #1 chk("rst_hold_before", bin, 0);
      @(posedge clk);
      #1 chk("rst_hold_step", bin, 1);
      @(negedge clk);
      btn_up = 1'b0;
      cyc(int'(D) + 8);

      repeat (150) begin
         if ($urandom_range(0, 99) < 3) begin
            rst = 1'b1;
            cyc(1 + $urandom_range(0, 2));
            rst = 1'b0;
         end else begin
            btn_up   = 1'($urandom_range(0, 1));
            btn_down = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 25));
         end
      end
      btn_up   = 1'b0;
      btn_down = 1'b0;
      cyc(int'(D) + 8);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_code_generator.md
# gray_code_generator

Sequential source side of the Gray-code display path: two debounced push-buttons step a 4-bit counter up/down, and the block emits the matching 4-bit Gray code. That code is the stimulus the Gray-to-binary decoder, LED and 7-segment chain consumes. The block also time-multiplexes the two-digit display, units and tens, over one shared segment bus. Its alternating transistor enables replace manual digit selection by buttons.

## Interface
- DEBOUNCE_CYCLES, 10: consecutive stable synchronized samples required to accept a button level change; ≥2. Board builds override it, e.g. 270000.
- REFRESH_CYCLES, 4: clock cycles each digit stays selected; ≥2.
- clk  in  1  single system clock
- rst  in  1  reset, synchronous, active-high
- btn_up  in  1  raw step-up button, asynchronous, active-high
- btn_down  in  1  raw step-down button, asynchronous, active-high
- GrayCode  out  4  Gray encoding of count, registered
- bin  out  4  current count, registered
- changed  out  1  one-cycle pulse when count updates
- seg  out  7  {a,b,c,d,e,f,g}, active-high segments of the selected digit, registered
- transistor_unidades  out  1  units digit enable, active-high
- transistor_decenas  out  1  tens digit enable, active-high

## Operation
- Per button: 2-FF synchronizer, then debouncer.
  - The debouncer holds a debounced level and a stability counter.
  - The counter clears whenever the synchronized value equals the debounced level.
  - Otherwise it increments. On reaching DEBOUNCE_CYCLES−1 with a mismatch, the debounced level takes the synchronized value and the counter clears.
- Step pulse: one cycle on each rising edge of the debounced level. Releases never step.
- Count update, registered:
  - up only: count+1 mod 16, so 15→0.
  - down only: count−1 mod 16, so 0→15.
  - both in the same cycle: no change, and changed stays 0.
- GrayCode = next_count ^ (next_count >> 1). It is registered on the same edge as bin, so GrayCode and bin are never inconsistent.
- changed = 1 for exactly the cycle after a count update.
- Digit values:
  - units = bin mod 10, so 10..15 → 0..5.
  - tens = 1 when bin ≥ 10, else blank.
- Segment patterns (abcdefg):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011
  - 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011
  - blank=0000000
- Display mux:
  - A refresh counter runs 0..REFRESH_CYCLES−1.
  - At terminal count, digit select toggles between UNITS and TENS.
  - seg, transistor_unidades and transistor_decenas all register on that same edge, so segments always match the enabled digit.
  - Exactly one enable is high at all times after reset.
  - The mux runs independently of stepping. A count change mid-slot appears at the next toggle edge.

## Timing
- Reset values:
  - bin=0000, GrayCode=0000, changed=0.
  - seg=1111110 (units "0"), transistor_unidades=1, transistor_decenas=0.
  - Debounced levels=0, synchronizers=0, all counters=0, select=UNITS.
- Step latency: with a button held stable high from edge E0, the first edge that samples it high, bin/GrayCode update at edge E0+DEBOUNCE_CYCLES+3 and changed is high for the following cycle.
- Glitch rejection: a level held fewer than DEBOUNCE_CYCLES synchronized samples produces no step.
- Holding a button produces exactly one step. There is no auto-repeat.
- Refresh: each enable stays high REFRESH_CYCLES cycles, then swaps. The first swap occurs at edge REFRESH_CYCLES after reset release.
- Reset mid-operation has priority over everything. A pending debounce or step is discarded, and the cycle after reset deassertion matches the reset values.
- A button held through reset release must complete a full debounce before it steps.

## Test plan
- Reset, buttons low, 40 cycles:
  - bin=0, GrayCode=0000, changed never 1.
  - Enables alternate every 4 cycles starting with units.
  - seg=1111110 while units is selected, 0000000 while tens is selected.
- btn_up high from edge E0, held 30 cycles (DEBOUNCE_CYCLES=10) → bin=1 and GrayCode=0001 at E0+13, changed=1 for one cycle, no further steps.
- Up-press ×15 from 0 → bin=15, GrayCode=1000; one more press → bin=0, GrayCode=0000. Then down-press from 0 → bin=15, GrayCode=1000.
- btn_up pulses of 5 cycles separated by 5 low cycles, repeated 10 times → no step. Both buttons debounced on the same edge → bin unchanged, changed=0.
- Step bin to 12 (GrayCode=1010) → units slots show seg=1101101 with transistor_unidades=1, tens slots show 0110000 with transistor_decenas=1. Enables never both high.
- rst asserted for 1 cycle while btn_up is mid-debounce with bin=7 → all outputs return to reset values next cycle. btn_up still held after release → bin=1 exactly DEBOUNCE_CYCLES+3 edges after reset deassertion.
